// File: rtl/pulse_iface_rx.sv
// Pulse parameter capture FIFO; PULSE_IFACE_RX_DROP_CNT_EN adds a saturating drop counter.
// Latency: a strobe on an empty FIFO is visible on the outputs right after the capturing edge.
// Backpressure: head is held while out_ready is low; a strobe into a full FIFO with no pop is dropped.
module pulse_iface_rx #(
    parameter int DEPTH          = 4,
    parameter int ENV_WORD_WIDTH = 24,
    parameter int FREQ_WIDTH     = 9,
    parameter int PHASE_WIDTH    = 17,
    parameter int AMP_WIDTH      = 16,
    parameter int CFG_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ENV_WORD_WIDTH-1:0] env_word,
    input  logic [PHASE_WIDTH-1:0]    phase,
    input  logic [FREQ_WIDTH-1:0]     freq,
    input  logic [AMP_WIDTH-1:0]      amp,
    input  logic [CFG_WIDTH-1:0]      cfg,
    input  logic                      cstrobe,
    output logic [ENV_WORD_WIDTH-1:0] out_env_word,
    output logic [PHASE_WIDTH-1:0]    out_phase,
    output logic [FREQ_WIDTH-1:0]     out_freq,
    output logic [AMP_WIDTH-1:0]      out_amp,
    output logic [CFG_WIDTH-1:0]      out_cfg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
`ifdef PULSE_IFACE_RX_DROP_CNT_EN
    input  logic                      clr_overflow,
    output logic [15:0]               drop_cnt
`else
    input  logic                      clr_overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int W  = ENV_WORD_WIDTH + PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH + CFG_WIDTH;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pulse_iface_rx: DEPTH must be a power of two in 2..16");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  wr_dat;
    logic [W-1:0]  head_dat;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

    assign wr_dat = {env_word, phase, freq, amp, cfg};

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a strobe then.
    assign pop  = out_valid & out_ready;
    assign push = cstrobe & (~full | pop);
    assign drop = cstrobe & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef PULSE_IFACE_RX_DROP_CNT_EN
    // A drop coinciding with a clear restarts the count at one rather than losing the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr_overflow)             drop_cnt <= 16'd1;
            else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else if (clr_overflow) begin
            drop_cnt <= '0;
        end
    end
`endif

    // Storage is not reset, so the head is masked while empty.
    assign head_dat  = empty ? '0 : mem[rp[AW-1:0]];
    assign {out_env_word, out_phase, out_freq, out_amp, out_cfg} = head_dat;

    assign out_valid = ~empty;
    assign level     = wp - rp;

endmodule

// File: tb/tb_pulse_iface_rx.sv
// Bench for pulse_iface_rx: vector table, hand-written corner sequences, and random traffic against a queue model.
module tb_pulse_iface_rx;

    localparam int DEPTH = 4;
    localparam int EW    = 24;
    localparam int FW    = 9;
    localparam int PHW   = 17;
    localparam int AMW   = 16;
    localparam int CW    = 4;
    localparam int W     = EW + PHW + FW + AMW + CW;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [EW-1:0]  env_word = '0;
    logic [PHW-1:0] phase = '0;
    logic [FW-1:0]  freq = '0;
    logic [AMW-1:0] amp = '0;
    logic [CW-1:0]  cfg = '0;
    logic           cstrobe = 1'b0;
    logic [EW-1:0]  out_env_word;
    logic [PHW-1:0] out_phase;
    logic [FW-1:0]  out_freq;
    logic [AMW-1:0] out_amp;
    logic [CW-1:0]  out_cfg;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [LW-1:0]  level;
    logic           overflow;
    logic           clr_overflow = 1'b0;
`ifdef PULSE_IFACE_RX_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    pulse_iface_rx #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .env_word     (env_word),
        .phase        (phase),
        .freq         (freq),
        .amp          (amp),
        .cfg          (cfg),
        .cstrobe      (cstrobe),
        .out_env_word (out_env_word),
        .out_phase    (out_phase),
        .out_freq     (out_freq),
        .out_amp      (out_amp),
        .out_cfg      (out_cfg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
`ifdef PULSE_IFACE_RX_DROP_CNT_EN
        .clr_overflow (clr_overflow),
        .drop_cnt     (drop_cnt)
`else
        .clr_overflow (clr_overflow)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [W-1:0] d, input logic r, input logic c);
        {env_word, phase, freq, amp, cfg} = d;
        cstrobe      = s;
        out_ready    = r;
        clr_overflow = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: entries in a queue, pop happens before push, drops leave the queue untouched.
    logic [W-1:0] q[$];
    logic         m_ovf  = 1'b0;
    int           m_dcnt = 0;

    task automatic compare_model(input string tag);
        logic [W-1:0] e;
        e = (q.size() > 0) ? q[0] : '0;
        check({tag, "_vld"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, "_lvl"}, 32'(level), 32'(q.size()));
        check({tag, "_env"}, 32'(out_env_word), 32'(e[W-1 -: EW]));
        check({tag, "_phase"}, 32'(out_phase), 32'(e[W-EW-1 -: PHW]));
        check({tag, "_freq"}, 32'(out_freq), 32'(e[FW+AMW+CW-1 -: FW]));
        check({tag, "_amp"}, 32'(out_amp), 32'(e[AMW+CW-1 -: AMW]));
        check({tag, "_cfg"}, 32'(out_cfg), 32'(e[CW-1:0]));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef PULSE_IFACE_RX_DROP_CNT_EN
        check({tag, "_dcnt"}, 32'(drop_cnt), 32'(m_dcnt));
`endif
    endtask

    task automatic model_cycle(input string tag, input logic s, input logic [W-1:0] d,
                               input logic r, input logic c);
        bit do_pop, do_push, do_drop;
        drive(s, d, r, c);
        do_pop  = r && (q.size() > 0);
        do_push = s && ((q.size() < DEPTH) || do_pop);
        do_drop = s && !do_push;
        tick();
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(d);
        if (do_drop) begin
            m_ovf  = 1'b1;
            m_dcnt = c ? 1 : ((m_dcnt == 16'hFFFF) ? m_dcnt : m_dcnt + 1);
        end else if (c) begin
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end
        compare_model(tag);
    endtask

    typedef struct {
        logic        stb;
        logic [15:0] amp;
        logic        rdy;
        logic        clr;
        logic        vld;
        int          lvl;
        logic [15:0] eamp;
        logic        ovf;
        int          dcnt;
    } vec_t;

    function automatic vec_t mk(input logic stb, input logic [15:0] a, input logic rdy, input logic clr,
                                input logic vld, input int lvl, input logic [15:0] eamp,
                                input logic ovf, input int dcnt);
        vec_t v;
        v.stb = stb; v.amp = a; v.rdy = rdy; v.clr = clr;
        v.vld = vld; v.lvl = lvl; v.eamp = eamp; v.ovf = ovf; v.dcnt = dcnt;
        return v;
    endfunction

    vec_t tbl[38];

    initial begin
        logic [W-1:0] d;
        int           bias;

        // Single pulse, then fill-and-drain in order.
        tbl[0]  = mk(1, 16'h7FFF, 0, 0, 1, 1, 16'h7FFF, 0, 0);
        tbl[1]  = mk(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0);
        tbl[2]  = mk(1, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0);
        tbl[3]  = mk(1, 16'd2, 0, 0, 1, 2, 16'd1, 0, 0);
        tbl[4]  = mk(1, 16'd3, 0, 0, 1, 3, 16'd1, 0, 0);
        tbl[5]  = mk(1, 16'd4, 0, 0, 1, 4, 16'd1, 0, 0);
        tbl[6]  = mk(0, 16'd0, 1, 0, 1, 3, 16'd2, 0, 0);
        tbl[7]  = mk(0, 16'd0, 1, 0, 1, 2, 16'd3, 0, 0);
        tbl[8]  = mk(0, 16'd0, 1, 0, 1, 1, 16'd4, 0, 0);
        tbl[9]  = mk(0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 0);
        // Overflow on a fifth strobe, drain 1..4, then clear.
        tbl[10] = mk(1, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0);
        tbl[11] = mk(1, 16'd2, 0, 0, 1, 2, 16'd1, 0, 0);
        tbl[12] = mk(1, 16'd3, 0, 0, 1, 3, 16'd1, 0, 0);
        tbl[13] = mk(1, 16'd4, 0, 0, 1, 4, 16'd1, 0, 0);
        tbl[14] = mk(1, 16'd5, 0, 0, 1, 4, 16'd1, 1, 1);
        tbl[15] = mk(0, 16'd0, 1, 0, 1, 3, 16'd2, 1, 1);
        tbl[16] = mk(0, 16'd0, 1, 0, 1, 2, 16'd3, 1, 1);
        tbl[17] = mk(0, 16'd0, 1, 0, 1, 1, 16'd4, 1, 1);
        tbl[18] = mk(0, 16'd0, 1, 0, 0, 0, 16'd0, 1, 1);
        tbl[19] = mk(0, 16'd0, 0, 1, 0, 0, 16'd0, 0, 0);
        // Push and pop together while full.
        tbl[20] = mk(1, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0);
        tbl[21] = mk(1, 16'd2, 0, 0, 1, 2, 16'd1, 0, 0);
        tbl[22] = mk(1, 16'd3, 0, 0, 1, 3, 16'd1, 0, 0);
        tbl[23] = mk(1, 16'd4, 0, 0, 1, 4, 16'd1, 0, 0);
        tbl[24] = mk(1, 16'd9, 1, 0, 1, 4, 16'd2, 0, 0);
        tbl[25] = mk(0, 16'd0, 1, 0, 1, 3, 16'd3, 0, 0);
        tbl[26] = mk(0, 16'd0, 1, 0, 1, 2, 16'd4, 0, 0);
        tbl[27] = mk(0, 16'd0, 1, 0, 1, 1, 16'd9, 0, 0);
        tbl[28] = mk(0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 0);
        // Drop coinciding with clear: set wins, counter restarts at one.
        tbl[29] = mk(1, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0);
        tbl[30] = mk(1, 16'd2, 0, 0, 1, 2, 16'd1, 0, 0);
        tbl[31] = mk(1, 16'd3, 0, 0, 1, 3, 16'd1, 0, 0);
        tbl[32] = mk(1, 16'd4, 0, 0, 1, 4, 16'd1, 0, 0);
        tbl[33] = mk(1, 16'd5, 0, 1, 1, 4, 16'd1, 1, 1);
        tbl[34] = mk(0, 16'd0, 1, 1, 1, 3, 16'd2, 0, 0);
        tbl[35] = mk(0, 16'd0, 1, 0, 1, 2, 16'd3, 0, 0);
        tbl[36] = mk(0, 16'd0, 1, 0, 1, 1, 16'd4, 0, 0);
        tbl[37] = mk(0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 0);

        #12;
        compare_model("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 38; i++) begin
            drive(tbl[i].stb, {24'h000123, 17'h1_0000, 9'h0AB, tbl[i].amp, 4'h3}, tbl[i].rdy, tbl[i].clr);
            tick();
            check($sformatf("t%0d_vld", i), 32'(out_valid), 32'(tbl[i].vld));
            check($sformatf("t%0d_lvl", i), 32'(level), 32'(tbl[i].lvl));
            check($sformatf("t%0d_amp", i), 32'(out_amp), 32'(tbl[i].eamp));
            check($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            check($sformatf("t%0d_env", i), 32'(out_env_word), tbl[i].vld ? 32'h123 : 32'h0);
            check($sformatf("t%0d_phase", i), 32'(out_phase), tbl[i].vld ? 32'h10000 : 32'h0);
            check($sformatf("t%0d_freq", i), 32'(out_freq), tbl[i].vld ? 32'h0AB : 32'h0);
            check($sformatf("t%0d_cfg", i), 32'(out_cfg), tbl[i].vld ? 32'h3 : 32'h0);
`ifdef PULSE_IFACE_RX_DROP_CNT_EN
            check($sformatf("t%0d_dcnt", i), 32'(drop_cnt), 32'(tbl[i].dcnt));
`endif
        end

        // Continuous strobe with the consumer always ready: each entry shows one cycle late.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {24'h0, 17'h0, 9'h0, 16'(i), 4'h0}, 1'b1, 1'b0);
            tick();
            check($sformatf("wrap%0d_amp", i), 32'(out_amp), 32'(i));
            check($sformatf("wrap%0d_vld", i), 32'(out_valid), 32'd1);
            check($sformatf("wrap%0d_lvl_le1", i), 32'(level <= 1), 32'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("wrap_end_lvl", 32'(level), 32'd0);

        // Fill, three drops, one pop -> level 3 with overflow set, then reset between edges.
        for (int i = 0; i < 7; i++) begin
            d = W'({$urandom(), $urandom(), $urandom()});
            model_cycle($sformatf("pre_rst%0d", i), 1'b1, d, 1'b0, 1'b0);
        end
        model_cycle("pre_rst_pop", 1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_lvl3", 32'(level), 32'd3);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf  = 1'b0;
        m_dcnt = 0;
        compare_model("in_rst");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) model_cycle($sformatf("post_rst%0d", i), 1'b0, '0, 1'b1, 1'b0);
        model_cycle("post_rst_push", 1'b1, W'({$urandom(), $urandom(), $urandom()}), 1'b0, 1'b0);

        // Random traffic; ready bias alternates so both full and empty regimes are exercised.
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 100) % 2 == 0) ? 25 : 80;
            d = W'({$urandom(), $urandom(), $urandom()});
            model_cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), d,
                        1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_iface_rx.md
# pulse_iface_rx

Receive end of `pulse_iface`: captures the pulse parameter set (env_word, phase, freq, amp, cfg) on each `cstrobe` and queues it in a small FIFO. The FIFO drains toward the signal-generator element over a valid/ready handshake, so a proc core can issue back-to-back pulses while the element is still consuming earlier ones. Sits between a proc core's pulse register stage and one DAC/envelope element.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `ENV_WORD_WIDTH`, `FREQ_WIDTH`, `PHASE_WIDTH`, `AMP_WIDTH`, `CFG_WIDTH`: localparams taken from `pulsein`; bench widths are 24/9/17/16/4.
- `W` = sum of the five widths: the entry width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pulsein` pulse_iface: env_word, phase, freq, amp, cfg, cstrobe.
- `out_env_word`, `out_phase`, `out_freq`, `out_amp`, `out_cfg` output (widths per field): head entry fields.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: consumer accepts the head entry.
- `level` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when a strobe is dropped.
- `clr_overflow` input 1: synchronous clear of `overflow`.

## Operation
- Entry packing, MSB to LSB: {env_word, phase, freq, amp, cfg}.
- Storage is a register array with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH)+1 bits (extra wrap bit).
- Full: `wp` and `rp` differ only in the MSB. Empty: `wp == rp`.
- Push: `cstrobe` high and (not full, or a pop occurs in the same cycle). The sampled fields are written at `wp` and `wp` increments.
- Pop: `out_valid & out_ready`. `rp` increments.
- Drop: `cstrobe` high, FIFO full, no pop that cycle. The entry is discarded and `overflow` is set to 1. Pointers and stored data do not change.
- Simultaneous push and pop at any level: both happen and `level` is unchanged.
- Simultaneous push and pop on an empty FIFO: the pop is impossible (`out_valid` = 0), so only the push happens.
- `overflow`: set has priority over `clr_overflow` in the same cycle.
- `level` = `wp - rp`, computed modulo 2·DEPTH.
- Output fields are a combinational read of the entry at `rp`. They are held stable while `out_valid & ~out_ready`.
- Pointer wrap-around is natural binary rollover, so non-power-of-two DEPTH is not allowed.

## Timing
- Reset values: `wp` = `rp` = 0, `out_valid` = 0, `level` = 0, `overflow` = 0, output fields = 0.
- Storage array is not reset. Outputs are forced to 0 while empty.
- Latency: `cstrobe` sampled at edge N on an empty FIFO gives `out_valid` = 1 and the fields visible after edge N.
- Throughput: one push and one pop per cycle.
- `out_valid` deasserts in the cycle after the last entry is popped, unless a push coincides with that pop.
- Reset asserted mid-operation: everything clears immediately. Pending entries are lost and `overflow` is cleared. The first edge after deassertion behaves as a fresh empty FIFO.
- `clr_overflow` takes effect at the next edge.

## Configuration
- `PULSE_IFACE_RX_DROP_CNT_EN`
  - Defined: adds output `drop_cnt` [15:0]. It increments on every dropped strobe, saturates at 16'hFFFF, resets to 0, and clears with `clr_overflow`. If a drop and `clr_overflow` occur in the same cycle, the result is 1.
  - Undefined: the port is absent and only the sticky `overflow` exists.

## Test plan
- Single pulse: reset, then one `cstrobe` with env=24'h000123, phase=17'h1_0000, freq=9'h0AB, amp=16'h7FFF, cfg=4'h3, `out_ready` = 0.
  - Expect `out_valid` = 1 and fields exact one cycle later, `level` = 1.
  - Raise `out_ready` for one cycle: `out_valid` = 0, `level` = 0.
- Fill and order: `out_ready` = 0, four strobes with amp = 1, 2, 3, 4.
  - Expect `level` = 4.
  - Drain with `out_ready` = 1: amp 1, 2, 3, 4 in order on consecutive cycles, with no `overflow`.
- Overflow: fill to 4, then a fifth strobe with amp = 5 and `out_ready` = 0.
  - Expect `overflow` = 1, `level` = 4, and a drain returning 1..4 only.
  - `clr_overflow` pulse: `overflow` = 0.
- Full push+pop: at `level` = 4, strobe amp = 9 with `out_ready` = 1 in the same cycle.
  - Expect no `overflow`, `level` stays 4, and the last drained entry has amp = 9.
- Wrap-around: 10 cycles of a continuous strobe plus `out_ready` = 1 with amp = 0..9.
  - Expect outputs 0..9 each one cycle late, and `level` never above 1.
- Async reset mid-run: `level` = 3, then pulse `rst_n` low between edges.
  - Expect `out_valid` = 0, `level` = 0 and `overflow` = 0 immediately, with no entries emitted after release.
  - With `PULSE_IFACE_RX_DROP_CNT_EN`: 3 drops give `drop_cnt` = 3, and reset gives 0.
